// File: rtl/seg_scan_bcd.sv
// Multiplexed 7-segment driver: binary value in over valid/ready, sequential
// shift-add-3 BCD conversion, then a DIGITS-wide common-anode scan with blink/dp/LZ.

module seg_scan_glyph #(
  parameter bit LAST = 1'b0
) (
  input  logic [3:0] nib,
  input  logic       upper_zero,
  input  logic       blank_lz,
  input  logic       blink,
  input  logic       phase_on,
  input  logic       dp,
  input  logic       ovf,
  output logic [7:0] glyph
);
  always_comb begin
    case (nib)
      4'd0:    glyph = 8'hC0;
      4'd1:    glyph = 8'hF9;
      4'd2:    glyph = 8'hA4;
      4'd3:    glyph = 8'hB0;
      4'd4:    glyph = 8'h99;
      4'd5:    glyph = 8'h92;
      4'd6:    glyph = 8'h82;
      4'd7:    glyph = 8'hF8;
      4'd8:    glyph = 8'h80;
      4'd9:    glyph = 8'h90;
      default: glyph = 8'hFF;
    endcase
    // later overrides win: LZ blank keeps dp, blink blanks dp too, overflow dashes everything
    if (blank_lz && upper_zero && (nib == 4'd0) && !LAST) glyph = 8'hFF;
    if (dp) glyph[7] = 1'b0;
    if (blink && !phase_on) glyph = 8'hFF;
    if (ovf) glyph = 8'hBF;
  end
endmodule

module seg_scan_bcd #(
  parameter int DIGITS        = 4,
  parameter int VAL_W         = 10,
  parameter int SEG_FLASH_DUR = 49_999,
  parameter int BLINK_DIV     = 25
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              val_valid,
  input  logic [VAL_W-1:0]  val_data,
  output logic              val_ready,
  input  logic              blank_lz,
  input  logic [DIGITS-1:0] blink_en,
  input  logic [DIGITS-1:0] dp_en,
  output logic [DIGITS-1:0] seg_sel,
  output logic [7:0]        seg_data,
  output logic              overflow
);
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int k = 0; k < n; k++) r = r * 64'd10;
    return r;
  endfunction

  // work register must hold every decimal digit of a VAL_W-bit value
  localparam int WN     = ((VAL_W + 3) / 3 > DIGITS) ? (VAL_W + 3) / 3 : DIGITS;
  localparam int CNT_W  = $clog2(VAL_W + 1);
  localparam int DIG_W  = $clog2(DIGITS);
  localparam int SLOT_W = (SEG_FLASH_DUR > 0) ? $clog2(SEG_FLASH_DUR + 1) : 1;
  localparam int FRM_W  = $clog2(BLINK_DIV + 1);
  localparam logic [63:0] OVF_LIM = pow10(DIGITS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_LOAD = 2'd2;

  logic [1:0]               state;
  logic [CNT_W-1:0]         cnt;
  logic [VAL_W-1:0]         work_bin;
  logic [WN*4-1:0]          work_bcd;
  logic [WN*4-1:0]          adj;
  logic                     ovf_next;
  logic [DIGITS-1:0][3:0]   disp_bcd;

  logic [SLOT_W-1:0]        slot_cnt;
  logic [DIG_W-1:0]         digit;
  logic [FRM_W-1:0]         frame_cnt;
  logic                     phase_on;
  logic [DIGITS-1:0]        upper_zero;
  logic [DIGITS-1:0][7:0]   glyphs;

  assign val_ready = (state == S_IDLE);

  always_comb begin
    adj = work_bcd;
    for (int k = 0; k < WN; k++)
      if (work_bcd[k*4 +: 4] >= 4'd5) adj[k*4 +: 4] = work_bcd[k*4 +: 4] + 4'd3;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      work_bin <= '0;
      work_bcd <= '0;
      ovf_next <= 1'b0;
      overflow <= 1'b0;
      disp_bcd <= '0;
    end else begin
      case (state)
        S_IDLE: if (val_valid) begin
          state    <= S_CONV;
          work_bin <= val_data;
          work_bcd <= '0;
          cnt      <= '0;
          ovf_next <= 64'(val_data) >= OVF_LIM;
        end
        S_CONV: begin
          {work_bcd, work_bin} <= {adj[WN*4-2:0], work_bin, 1'b0};
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(VAL_W - 1)) state <= S_LOAD;
        end
        S_LOAD: begin
          // digits and overflow flip together so the scan never shows a torn value
          disp_bcd <= work_bcd[DIGITS*4-1:0];
          overflow <= ovf_next;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt  <= '0;
      digit     <= '0;
      frame_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (slot_cnt == SLOT_W'(SEG_FLASH_DUR)) begin
      slot_cnt <= '0;
      if (digit == DIG_W'(DIGITS - 1)) begin
        digit <= '0;
        if (frame_cnt == FRM_W'(BLINK_DIV - 1)) begin
          frame_cnt <= '0;
          phase_on  <= ~phase_on;
        end else begin
          frame_cnt <= frame_cnt + FRM_W'(1);
        end
      end else begin
        digit <= digit + DIG_W'(1);
      end
    end else begin
      slot_cnt <= slot_cnt + SLOT_W'(1);
    end
  end

  // upper_zero[i]: every digit left of i (more significant) is zero
  always_comb begin
    logic z;
    z = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      upper_zero[k] = z;
      z = z & (disp_bcd[DIGITS-1-k] == 4'd0);
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    seg_scan_glyph #(.LAST(g == DIGITS - 1)) u_glyph (
      .nib        (disp_bcd[DIGITS-1-g]),
      .upper_zero (upper_zero[g]),
      .blank_lz   (blank_lz),
      .blink      (blink_en[g]),
      .phase_on   (phase_on),
      .dp         (dp_en[g]),
      .ovf        (overflow),
      .glyph      (glyphs[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_sel  <= '0;
      seg_data <= 8'hFF;
    end else begin
      seg_sel  <= DIGITS'(1) << digit;
      seg_data <= glyphs[digit];
    end
  end
endmodule
